// File: rtl/mul_wb_merge.sv
// Merges multiply-pipe results with ALU results onto the single register-file write port.
// ALU writes always win; multiply results that lose arbitration wait in a small in-order FIFO.
module mul_wb_merge #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mul_valid,
    input  logic [W-1:0] mul_result,
    input  logic         mul_zero,
    input  logic         mul_overflow,
    input  logic [4:0]   mul_dst,
    output logic         mul_stall,
    input  logic         alu_valid,
    input  logic [W-1:0] alu_result,
    input  logic [4:0]   alu_dst,
    output logic         wb_en,
    output logic [W-1:0] wb_data,
    output logic [4:0]   wb_dst,
    output logic         wb_zero,
    output logic         ovf_exc,
    output logic [4:0]   ovf_dst
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [W-1:0] fifo_data [DEPTH];
    logic         fifo_zero [DEPTH];
    logic [4:0]   fifo_dst  [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic accept;
    logic mul_keep;
    logic mul_ovf;
    logic alu_write;
    logic fifo_nonempty;
    logic pop;
    logic bypass;
    logic push;

    // Stall comes from the registered count, so a pop from a full FIFO frees space next cycle.
    assign mul_stall = (count == FULL);

    always_comb begin
        accept        = mul_valid && !mul_stall;
        mul_keep      = accept && (mul_dst != '0) && !mul_overflow;
        mul_ovf       = accept && (mul_dst != '0) && mul_overflow;
        alu_write     = alu_valid && (alu_dst != '0);
        fifo_nonempty = (count != '0);
        pop           = !alu_write && fifo_nonempty;
        bypass        = !alu_write && !fifo_nonempty && mul_keep;
        push          = mul_keep && !bypass;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mul_result;
            fifo_zero[wr_ptr] <= mul_zero;
            fifo_dst[wr_ptr]  <= mul_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Write port: ALU, then queued head, then bypass; data/dst/zero hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_data <= '0;
            wb_dst  <= '0;
            wb_zero <= 1'b0;
        end else if (alu_write) begin
            wb_en   <= 1'b1;
            wb_data <= alu_result;
            wb_dst  <= alu_dst;
            wb_zero <= (alu_result == '0);
        end else if (pop) begin
            wb_en   <= 1'b1;
            wb_data <= fifo_data[rd_ptr];
            wb_dst  <= fifo_dst[rd_ptr];
            wb_zero <= fifo_zero[rd_ptr];
        end else if (bypass) begin
            wb_en   <= 1'b1;
            wb_data <= mul_result;
            wb_dst  <= mul_dst;
            wb_zero <= mul_zero;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_exc <= 1'b0;
            ovf_dst <= '0;
        end else begin
            ovf_exc <= mul_ovf;
            if (mul_ovf) begin
                ovf_dst <= mul_dst;
            end
        end
    end

endmodule

// File: tb/tb_mul_wb_merge.sv
// Scoreboard bench for mul_wb_merge: each driven cycle pushes the expected write-port state,
// a negedge monitor pops and compares it against the registered outputs.
module tb_mul_wb_merge;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         mul_valid;
    logic [W-1:0] mul_result;
    logic         mul_zero;
    logic         mul_overflow;
    logic [4:0]   mul_dst;
    logic         mul_stall;
    logic         alu_valid;
    logic [W-1:0] alu_result;
    logic [4:0]   alu_dst;
    logic         wb_en;
    logic [W-1:0] wb_data;
    logic [4:0]   wb_dst;
    logic         wb_zero;
    logic         ovf_exc;
    logic [4:0]   ovf_dst;

    mul_wb_merge #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mul_valid(mul_valid), .mul_result(mul_result), .mul_zero(mul_zero),
        .mul_overflow(mul_overflow), .mul_dst(mul_dst), .mul_stall(mul_stall),
        .alu_valid(alu_valid), .alu_result(alu_result), .alu_dst(alu_dst),
        .wb_en(wb_en), .wb_data(wb_data), .wb_dst(wb_dst), .wb_zero(wb_zero),
        .ovf_exc(ovf_exc), .ovf_dst(ovf_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [4:0]   dst;
        logic         zero;
    } wr_t;

    typedef struct {
        logic         en;
        logic [W-1:0] data;
        logic [4:0]   dst;
        logic         zero;
        logic         ovf;
        logic [4:0]   ovf_dst;
    } exp_t;

    wr_t  mq[$];
    exp_t sb[$];
    wr_t  last;
    exp_t me;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   mon_on       = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (sb.size() == 0) begin
                tests_run++;
                if (wb_en !== 1'b0 || ovf_exc !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL unexpected_output wb_en=%b ovf_exc=%b expected 0/0", wb_en, ovf_exc);
                end
            end else begin
                me = sb.pop_front();
                tests_run++;
                if (wb_en !== me.en) begin
                    tests_failed++;
                    $display("FAIL wb_en got=%b exp=%b t=%0t", wb_en, me.en, $time);
                end
                tests_run++;
                if (wb_data !== me.data || wb_dst !== me.dst || wb_zero !== me.zero) begin
                    tests_failed++;
                    $display("FAIL wb_fields got=%h/%0d/%b exp=%h/%0d/%b t=%0t",
                             wb_data, wb_dst, wb_zero, me.data, me.dst, me.zero, $time);
                end
                tests_run++;
                if (ovf_exc !== me.ovf) begin
                    tests_failed++;
                    $display("FAIL ovf_exc got=%b exp=%b t=%0t", ovf_exc, me.ovf, $time);
                end
                if (me.ovf) begin
                    tests_run++;
                    if (ovf_dst !== me.ovf_dst) begin
                        tests_failed++;
                        $display("FAIL ovf_dst got=%0d exp=%0d t=%0t", ovf_dst, me.ovf_dst, $time);
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        alu_valid = 0; alu_dst = '0; alu_result = '0;
        mul_valid = 0; mul_result = '0; mul_zero = 0; mul_overflow = 0; mul_dst = '0;
    endtask

    task automatic apply_reset();
        exp_t e;
        drive_idle();
        reset = 1'b1;
        mq.delete();
        last = '{data: '0, dst: '0, zero: 1'b0};
        e = '{en: 1'b0, data: '0, dst: '0, zero: 1'b0, ovf: 1'b0, ovf_dst: '0};
        sb.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One clock of stimulus; a bench-side queue model predicts the write port one cycle later.
    task automatic step(input logic av, input logic [4:0] ad, input logic [W-1:0] ar,
                        input logic mv, input logic [W-1:0] mr, input logic mz,
                        input logic mo, input logic [4:0] md, output logic acc);
        exp_t e;
        wr_t  w;
        bit   stall;
        bit   keep;
        alu_valid = av; alu_dst = ad; alu_result = ar;
        mul_valid = mv; mul_result = mr; mul_zero = mz; mul_overflow = mo; mul_dst = md;
        reset = 1'b0;
        stall = (mq.size() == DEPTH);
        tests_run++;
        if (mul_stall !== stall) begin
            tests_failed++;
            $display("FAIL mul_stall got=%b exp=%b t=%0t", mul_stall, stall, $time);
        end
        acc   = mv && !stall;
        keep  = acc && (md != 0) && !mo;
        e.ovf = acc && (md != 0) && mo;
        e.ovf_dst = md;
        e.en  = 1'b1;
        if (av && ad != 0) begin
            w = '{data: ar, dst: ad, zero: (ar == 0)};
            if (keep) mq.push_back('{data: mr, dst: md, zero: mz});
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            if (keep) mq.push_back('{data: mr, dst: md, zero: mz});
        end else if (keep) begin
            w = '{data: mr, dst: md, zero: mz};
        end else begin
            e.en = 1'b0;
            w = last;
        end
        last   = w;
        e.data = w.data;
        e.dst  = w.dst;
        e.zero = w.zero;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (wb_en !== 1'b0 || mul_stall !== 1'b0 || ovf_exc !== 1'b0 || wb_data !== '0 || wb_dst !== '0) begin
            tests_failed++;
            $display("FAIL reset_state wb_en=%b stall=%b ovf=%b data=%h dst=%0d exp all 0",
                     wb_en, mul_stall, ovf_exc, wb_data, wb_dst);
        end
    endtask

    task automatic test_bypass();
        logic acc;
        step(0, 0, 0, 1, 32'h6, 0, 0, 5'd5, acc);
        tests_run++;
        if (wb_en !== 1'b1 || wb_data !== 32'h6 || wb_dst !== 5'd5 || wb_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass got en=%b data=%h dst=%0d z=%b exp 1/6/5/0", wb_en, wb_data, wb_dst, wb_zero);
        end
        idle(1);
        tests_run++;
        if (wb_en !== 1'b0 || wb_data !== 32'h6 || wb_dst !== 5'd5) begin
            tests_failed++;
            $display("FAIL hold got en=%b data=%h dst=%0d exp 0/6/5", wb_en, wb_data, wb_dst);
        end
    endtask

    task automatic test_conflict();
        logic acc;
        step(1, 5'd3, 32'h11, 1, 32'h22, 0, 0, 5'd4, acc);
        tests_run++;
        if (wb_en !== 1'b1 || wb_dst !== 5'd3 || wb_data !== 32'h11) begin
            tests_failed++;
            $display("FAIL conflict_alu got en=%b r%0d=%h exp r3=11", wb_en, wb_dst, wb_data);
        end
        idle(1);
        tests_run++;
        if (wb_en !== 1'b1 || wb_dst !== 5'd4 || wb_data !== 32'h22) begin
            tests_failed++;
            $display("FAIL conflict_mul got en=%b r%0d=%h exp r4=22", wb_en, wb_dst, wb_data);
        end
        idle(1);
    endtask

    task automatic test_fill();
        logic acc;
        int   idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 5'(10 + i), 32'hA0 + 32'(i), 1, 32'h100 + 32'(idx), 0, 0, 5'(20 + idx), acc);
            if (acc) idx++;
        end
        tests_run++;
        if (mul_stall !== 1'b1 || idx != 2) begin
            tests_failed++;
            $display("FAIL fill_stall got stall=%b accepts=%0d exp 1/2", mul_stall, idx);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, (idx < 4), 32'h100 + 32'(idx), 0, 0, 5'(20 + idx), acc);
            if (acc) idx++;
        end
        tests_run++;
        if (idx != 4) begin
            tests_failed++;
            $display("FAIL fill_accepts got=%0d exp=4", idx);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        logic acc;
        step(0, 0, 0, 1, 32'hDEAD, 0, 1, 5'd7, acc);
        tests_run++;
        if (ovf_exc !== 1'b1 || ovf_dst !== 5'd7 || wb_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow got ovf=%b dst=%0d wb_en=%b exp 1/7/0", ovf_exc, ovf_dst, wb_en);
        end
        step(1, 5'd3, 32'h0, 1, 32'h99, 0, 0, 5'd9, acc);
        step(1, 5'd4, 32'h44, 1, 32'h77, 0, 1, 5'd12, acc);
        idle(3);
    endtask

    task automatic test_r0();
        logic acc;
        step(1, 5'd0, 32'h55, 1, 32'h66, 0, 0, 5'd0, acc);
        tests_run++;
        if (wb_en !== 1'b0 || mul_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL r0 got wb_en=%b stall=%b exp 0/0", wb_en, mul_stall);
        end
        step(1, 5'd0, 32'h55, 1, 32'h0, 1, 0, 5'd8, acc);
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic acc;
        step(1, 5'd1, 32'h1, 1, 32'hAA, 0, 0, 5'd14, acc);
        step(1, 5'd2, 32'h2, 1, 32'hBB, 0, 0, 5'd15, acc);
        tests_run++;
        if (mul_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_full got stall=%b exp=1", mul_stall);
        end
        apply_reset();
        tests_run++;
        if (wb_en !== 1'b0 || mul_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid got wb_en=%b stall=%b exp 0/0", wb_en, mul_stall);
        end
        idle(3);
        step(0, 0, 0, 1, 32'h5A, 0, 0, 5'd6, acc);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic acc;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'(i * 3), (i == 0), 0, 5'(16 + i), acc);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 5)), acc);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        mon_on = 1'b1;
        test_reset();
        test_bypass();
        test_conflict();
        test_fill();
        test_overflow();
        test_r0();
        test_reset_mid();
        test_back_to_back();
        test_random();
        for (int i = 0; i < 2 * DEPTH + 2 && mq.size() > 0; i++) idle(1);
        idle(1);
        @(negedge clk); #1;
        tests_run++;
        if (sb.size() != 0 || mq.size() != 0) begin
            tests_failed++;
            $display("FAIL drain got sb=%0d mq=%0d exp 0/0", sb.size(), mq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
